// File: rtl/frame_reader.sv
// Frame reader: on START, fetches one DEPTH-word frame from the frame buffer RAM and
// streams it over valid/ready, checking header/footer markers and event continuity.
module frame_reader #(
    parameter int DEPTH  = 48,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_clr_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rden,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_dout_valid,
    input  logic              i_dout_ready,
    output logic              o_dout_last,
    output logic              o_busy,
    output logic              o_overrun,
    output logic              o_hdr_err,
    output logic              o_ftr_err,
    output logic              o_evt_err,
    output logic [15:0]       o_frame_cnt
);

    localparam int FIFO_D = RD_LAT + 2;
    localparam int CNT_W  = $clog2(FIFO_D + 1);
    localparam int PTR_W  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_D);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_D - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_issue_idx;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rden;
    logic              r_busy;
    logic              r_overrun;
    logic [15:0]       r_frame_cnt;
    logic [CNT_W-1:0]  r_out_cnt;
    logic [CNT_W-1:0]  r_fifo_cnt;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [DATA_W-1:0] r_fifo [FIFO_D];
    logic [RD_LAT-1:0] r_rd_pipe;
    logic [ADDR_W-1:0] r_wr_idx;
    logic [ADDR_W-1:0] r_beat_idx;
    logic [3:0]        r_last_evt;
    logic              r_evt_valid;
    logic              r_hdr_err;
    logic              r_ftr_err;
    logic              r_evt_err;

    logic              w_valid;
    logic              w_accept;
    logic              w_last;
    logic              w_push;
    logic [CNT_W-1:0]  w_out_next;
    logic              w_is_hdr;
    logic              w_is_ftr;
    logic [3:0]        w_evt;
    logic [3:0]        w_mark;
    logic              w_hdr_bad;
    logic              w_evt_bad;
    logic              w_ftr_bad;

    assign w_valid    = (r_fifo_cnt != '0);
    assign w_accept   = w_valid & i_dout_ready;
    assign w_last     = w_valid && (r_beat_idx == LAST_IDX);
    assign w_push     = r_rd_pipe[RD_LAT-1];
    // Outstanding words (in flight + buffered) as they will stand after this edge.
    assign w_out_next = r_out_cnt + CNT_W'(r_mem_rden) - CNT_W'(w_accept);

    assign w_is_hdr  = w_push && (r_wr_idx == '0);
    assign w_is_ftr  = w_push && (r_wr_idx == LAST_IDX);
    assign w_evt     = i_mem_data[3:0];
    assign w_mark    = i_mem_data[DATA_W-1 -: 4];
    assign w_hdr_bad = w_is_hdr && (w_mark != 4'hF);
    assign w_evt_bad = w_is_hdr && r_evt_valid && (w_evt != r_last_evt + 4'd1);
    assign w_ftr_bad = w_is_ftr && ((w_mark != 4'hE) || (w_evt != r_last_evt));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_issue_idx <= '0;
            r_mem_addr  <= '0;
            r_mem_rden  <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_cnt <= '0;
            r_out_cnt   <= '0;
        end else begin
            r_overrun <= i_start && (r_state != S_IDLE);
            r_out_cnt <= w_out_next;
            case (r_state)
                S_IDLE: begin
                    r_mem_rden <= 1'b0;
                    if (i_start) begin
                        r_state     <= S_READ;
                        r_busy      <= 1'b1;
                        r_mem_rden  <= 1'b1;
                        r_mem_addr  <= '0;
                        r_issue_idx <= ADDR_W'(1);
                    end
                end
                S_READ: begin
                    if (w_out_next < FIFO_FULL) begin
                        r_mem_rden  <= 1'b1;
                        r_mem_addr  <= r_issue_idx;
                        r_issue_idx <= r_issue_idx + ADDR_W'(1);
                        if (r_issue_idx == LAST_IDX) begin
                            r_state <= S_DRAIN;
                        end
                    end else begin
                        r_mem_rden <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    r_mem_rden <= 1'b0;
                    if (w_accept && w_last) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_mem_rden <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // Read-data pipeline, skid FIFO and marker checks.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_pipe   <= '0;
            r_fifo_cnt  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_wr_idx    <= '0;
            r_beat_idx  <= '0;
            r_last_evt  <= '0;
            r_evt_valid <= 1'b0;
            r_hdr_err   <= 1'b0;
            r_ftr_err   <= 1'b0;
            r_evt_err   <= 1'b0;
            for (int i = 0; i < FIFO_D; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            r_rd_pipe[0] <= r_mem_rden;
            for (int i = 1; i < RD_LAT; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
            if (w_push) begin
                r_fifo[r_wr_ptr] <= i_mem_data;
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
                r_wr_idx <= (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + ADDR_W'(1);
            end
            if (w_accept) begin
                r_rd_ptr   <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
                r_beat_idx <= w_last ? '0 : r_beat_idx + ADDR_W'(1);
            end
            r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_accept);
            if (w_is_hdr) begin
                r_last_evt  <= w_evt;
                r_evt_valid <= 1'b1;
            end
            // A new error in the clearing cycle still sets the bit.
            r_hdr_err <= (r_hdr_err & ~i_clr_err) | w_hdr_bad;
            r_ftr_err <= (r_ftr_err & ~i_clr_err) | w_ftr_bad;
            r_evt_err <= (r_evt_err & ~i_clr_err) | w_evt_bad;
        end
    end

    assign o_mem_addr   = r_mem_addr;
    assign o_mem_rden   = r_mem_rden;
    assign o_dout       = r_fifo[r_rd_ptr];
    assign o_dout_valid = w_valid;
    assign o_dout_last  = w_last;
    assign o_busy       = r_busy;
    assign o_overrun    = r_overrun;
    assign o_hdr_err    = r_hdr_err;
    assign o_ftr_err    = r_ftr_err;
    assign o_evt_err    = r_evt_err;
    assign o_frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: RAM model with 2-cycle latency, randomized ready and frames,
// and a frame-level reference model of the marker/continuity/count rules.
module tb_frame_reader;

    localparam int DEPTH = 48;

    logic        clk = 1'b0;
    logic        rst_n, start, clr_err, rden, ready, valid, last;
    logic        busy, overrun, hdr_err, ftr_err, evt_err;
    logic [5:0]  addr;
    logic [15:0] mem_data, dout, frame_cnt;

    always #5 clk = ~clk;

    frame_reader #(.DEPTH(DEPTH), .ADDR_W(6), .DATA_W(16), .RD_LAT(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_clr_err(clr_err),
        .o_mem_addr(addr), .o_mem_rden(rden), .i_mem_data(mem_data),
        .o_dout(dout), .o_dout_valid(valid), .i_dout_ready(ready), .o_dout_last(last),
        .o_busy(busy), .o_overrun(overrun), .o_hdr_err(hdr_err), .o_ftr_err(ftr_err),
        .o_evt_err(evt_err), .o_frame_cnt(frame_cnt)
    );

    logic [15:0] ram [64];
    logic [15:0] rp1 = '0;
    logic [15:0] rp2 = '0;
    always @(posedge clk) begin
        if (rden) rp1 <= ram[addr];
        rp2 <= rp1;
    end
    assign mem_data = rp2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
    int rdy_mode = 0;
    int rdy_ph   = 0;
    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: ready = 1'b1;
                1: begin ready = ((rdy_ph % 4) == 0) || ((rdy_ph % 4) == 3); rdy_ph++; end
                default: ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: collects accepted beats, checks stalls and outstanding reads.
    logic [15:0] got_q[$];
    bit          got_last_q[$];
    int          got_cyc_q[$];
    int          issued = 0, accepted = 0, ovr_cnt = 0;
    bit          done_seen = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_dout = '0;
    logic        prev_last = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                issued = 0; accepted = 0; prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 32'(valid), 32'd1);
                    chk("stall_dout", 32'(dout), 32'(prev_dout));
                    chk("stall_last", 32'(last), 32'(prev_last));
                end
                if (rden) begin
                    chk("outstanding_le4", 32'((issued - accepted + 1) <= 4), 32'd1);
                    issued++;
                end
                if (valid && ready) begin
                    got_q.push_back(dout);
                    got_last_q.push_back(last);
                    got_cyc_q.push_back(cyc);
                    accepted++;
                    if (last) done_seen = 1;
                end
                if (overrun) ovr_cnt++;
                prev_stall = valid && !ready;
                prev_dout  = dout;
                prev_last  = last;
            end
        end
    end

    // Reference model, one update per delivered frame.
    int m_prev = 0;
    bit m_have = 0;
    bit m_hdr = 0, m_ftr = 0, m_evt = 0;
    int m_fcnt = 0;

    task automatic model_frame(input logic [15:0] h, input logic [15:0] f);
        int ev;
        ev = int'(h[3:0]);
        if (h[15:12] != 4'hF) m_hdr = 1;
        if (m_have && ev != (m_prev + 1) % 16) m_evt = 1;
        m_prev = ev;
        m_have = 1;
        if (f[15:12] != 4'hE || int'(f[3:0]) != ev) m_ftr = 1;
        m_fcnt = (m_fcnt + 1) % 65536;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(m_fcnt));
        chk({tag, "_hdr_err"}, 32'(hdr_err), 32'(m_hdr));
        chk({tag, "_ftr_err"}, 32'(ftr_err), 32'(m_ftr));
        chk({tag, "_evt_err"}, 32'(evt_err), 32'(m_evt));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_rden"}, 32'(rden), 32'd0);
        chk({tag, "_addr"}, 32'(addr), 32'd0);
        chk({tag, "_dout"}, 32'(dout), 32'd0);
        chk({tag, "_last"}, 32'(last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
        chk({tag, "_errs"}, 32'({hdr_err, ftr_err, evt_err}), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    task automatic load_frame(input logic [15:0] h, input logic [15:0] f, input bit seq);
        ram[0] = h;
        for (int i = 1; i < DEPTH - 1; i++) ram[i] = seq ? 16'(i) : 16'($urandom);
        ram[DEPTH-1] = f;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        got_q.delete(); got_last_q.delete(); got_cyc_q.delete();
        done_seen = 0;
        start = 1'b1;
    endtask

    task automatic run_frame(input logic [15:0] h, input logic [15:0] f, input int mode,
                             input bit seq, input bit chk_lat, input int ovr_at);
        logic [15:0] exp_words [DEPTH];
        int s_cyc, ovr0, n, nbad;
        load_frame(h, f, seq);
        for (int i = 0; i < DEPTH; i++) exp_words[i] = ram[i];
        rdy_mode = mode;
        rdy_ph = 0;
        ovr0 = ovr_cnt;
        pulse_start();
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done_seen && n < 2000) begin
            @(negedge clk);
            n++;
            if (ovr_at > 0 && n == ovr_at) start = 1'b1;
            else start = 1'b0;
        end
        start = 1'b0;
        chk("frame_done", 32'(done_seen), 32'd1);
        repeat (3) @(negedge clk);
        if (ovr_at > 0) begin
            repeat (20) @(negedge clk);
            chk("overrun_pulses", 32'(ovr_cnt - ovr0), 32'd1);
        end else begin
            chk("no_overrun", 32'(ovr_cnt - ovr0), 32'd0);
        end
        chk("beat_count", 32'(got_q.size()), 32'(DEPTH));
        for (int i = 0; i < got_q.size() && i < DEPTH; i++)
            chk($sformatf("beat%0d", i), 32'(got_q[i]), 32'(exp_words[i]));
        nbad = 0;
        for (int i = 0; i < got_last_q.size(); i++)
            if (got_last_q[i] != (i == DEPTH - 1)) nbad++;
        chk("last_flag_errors", 32'(nbad), 32'd0);
        if (chk_lat && got_cyc_q.size() > 0)
            chk("first_beat_latency", 32'(got_cyc_q[0] - s_cyc), 32'd4);
        if (mode == 0 && got_cyc_q.size() == DEPTH)
            chk("contiguous_span", 32'(got_cyc_q[DEPTH-1] - got_cyc_q[0]), 32'(DEPTH - 1));
        model_frame(h, f);
        check_status($sformatf("frame%0d", m_fcnt));
        $display("[TB] frame hdr=%04h ftr=%04h mode=%0d beats=%0d cnt=%0d errs=%b%b%b",
                 h, f, mode, got_q.size(), frame_cnt, hdr_err, ftr_err, evt_err);
    endtask

    task automatic clear_errors();
        @(negedge clk); clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        m_hdr = 0; m_ftr = 0; m_evt = 0;
        @(negedge clk);
        chk("clr_errs", 32'({hdr_err, ftr_err, evt_err}), 32'd0);
        $display("[TB] clear errors -> %b%b%b", hdr_err, ftr_err, evt_err);
    endtask

    task automatic reset_mid_frame();
        int n;
        load_frame(16'hF204, 16'hE204, 0);
        rdy_mode = 0;
        pulse_start();
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (got_q.size() < 20 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reached_beat20", 32'(got_q.size() >= 20), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_have = 0; m_hdr = 0; m_ftr = 0; m_evt = 0; m_fcnt = 0;
        got_q.delete(); got_last_q.delete(); got_cyc_q.delete();
        repeat (30) @(negedge clk);
        chk("no_beats_after_reset", 32'(got_q.size()), 32'd0);
        chk("idle_after_reset", 32'(busy), 32'd0);
        $display("[TB] reset mid-frame, beats after release=%0d", got_q.size());
    endtask

    initial begin
        logic [15:0] h, f;
        int ev;
        rst_n = 1'b1; start = 1'b0; clr_err = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(16'hF201, 16'hE201, 0, 1, 1, 0);   // basic, latency and contiguity
        run_frame(16'hF202, 16'hE202, 1, 0, 0, 0);   // 1,0,0,1 backpressure
        run_frame(16'hF203, 16'hE203, 2, 0, 0, 0);   // random backpressure
        run_frame(16'hA204, 16'hE204, 0, 0, 0, 0);   // bad header marker
        run_frame(16'hF205, 16'hE201, 1, 0, 0, 0);   // footer event mismatch
        clear_errors();
        run_frame(16'hF30E, 16'hE30E, 0, 0, 0, 0);   // 5 -> E discontinuity
        clear_errors();
        run_frame(16'hF40F, 16'hE40F, 2, 0, 0, 0);
        run_frame(16'hF500, 16'hE500, 0, 0, 0, 0);   // wrap F -> 0 accepted
        run_frame(16'hF602, 16'hE602, 0, 0, 0, 0);   // 0 -> 2 discontinuity
        clear_errors();
        run_frame(16'hF703, 16'hE703, 0, 0, 0, 10);  // overrun mid-frame
        reset_mid_frame();
        run_frame(16'hF80B, 16'hE80B, 0, 0, 1, 0);   // first frame after reset

        for (int k = 0; k < 8; k++) begin
            ev = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : (m_prev + 1) % 16;
            h = {(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF), 8'($urandom), 4'(ev)};
            f = {(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hE), 8'($urandom),
                 (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(ev))};
            run_frame(h, f, int'($urandom_range(0, 2)), 0, 0, 0);
            if ($urandom_range(0, 2) == 0) clear_errors();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
